elevator_scheduler: RTL and testbench
=====================================

# elevator_scheduler

Car-motion sequencer for the 4-storey elevator controller. Latches car and hall calls, tracks the current floor and travel direction, and drives the run timer (`mv2nxt` / `endRun`) and the door timer (`opendoor` / `endOpen`) with a SCAN policy: keep going in one direction while calls remain ahead, then reverse. It sits between the button/lamp logic and the timer blocks, in the `CP` (clk4hz) domain.

## Interface
- NFLOOR, 4, number of floors; floors indexed 0..NFLOOR-1
- FW, 2, floor index width; must satisfy 2^FW >= NFLOOR
- CP  in  1  clock; all logic on posedge
- rst  in  1  asynchronous, active-high reset
- in_call  in  NFLOOR  car-panel buttons; a one-cycle pulse is enough
- up_call  in  NFLOOR  hall up buttons; bit NFLOOR-1 ignored
- dn_call  in  NFLOOR  hall down buttons; bit 0 ignored
- open_btn  in  1  car open button; acts only in IDLE
- endRun  in  1  run timer done (level; acted on in the first cycle seen)
- endOpen  in  1  door cycle done (level)
- mv2nxt  out  1  run-timer enable; low clears the run timer
- opendoor  out  1  door-timer enable; low clears the door timer
- floor  out  FW  current floor
- dir_up  out  1  1 = up, 0 = down
- pend_in / pend_up / pend_dn  out  NFLOOR each  latched calls, used for lamps

## Operation
- **Latching:** each edge, `pend_x <= pend_x | x_call`.
  - Calls for the current floor while in OPEN are discarded.
  - On entry to OPEN at floor f, `pend_in[f]`, `pend_up[f]` and `pend_dn[f]` all clear.
  - If a set and a clear hit the same bit in the same cycle, clear wins.
- **Derived signals** (from registered pend, OR of all three vectors):
  - `here` = any call at f.
  - `above` = any call at a floor > f.
  - `below` = any call at a floor < f.
- **States:** IDLE, RUN, ARRIVE, OPEN. Outputs are Moore and registered:
  - `mv2nxt` = 1 only in RUN.
  - `opendoor` = 1 only in OPEN.
- **IDLE** (evaluated in this priority order):
  - `here` or `open_btn` -> OPEN.
  - Else `dir_up & above` -> RUN, direction up.
  - Else `!dir_up & below` -> RUN, direction down.
  - Else `above` -> RUN, `dir_up` <= 1.
  - Else `below` -> RUN, `dir_up` <= 0.
  - Else stay in IDLE.
- **RUN:** on `endRun` = 1, floor <= floor +1 (up) or -1 (down), then -> ARRIVE.
- **ARRIVE** (one cycle, `mv2nxt` = 0 so the run timer restarts). Evaluated at the new floor f.
  - Moving up, stop if any of: `pend_in[f]`, `pend_up[f]`, `pend_dn[f] & !above`, or f == NFLOOR-1.
  - Moving down, stop if any of: `pend_in[f]`, `pend_dn[f]`, `pend_up[f] & !below`, or f == 0.
  - Stop -> OPEN. Otherwise -> RUN.
- **OPEN:** on `endOpen` = 1 -> IDLE. The IDLE cycle drops `opendoor` and re-evaluates calls.
- **Bounds:** floor never wraps. Up at NFLOOR-1 or down at 0 is never issued, because ARRIVE forces a stop there.
- **Reset** (async, immediate): state IDLE, floor 0, `dir_up` 1, all pend 0, `mv2nxt` 0, `opendoor` 0.
  - Reset mid-RUN drops `mv2nxt` at once; the floor reverts to 0.

## Timing
- A call high at edge E0 is visible in pend after E0.
- From IDLE, the IDLE decision is made at E1; `mv2nxt` or `opendoor` is high after E1.
- `endRun` seen at edge En:
  - floor updates after En.
  - `mv2nxt` is low for exactly one cycle (ARRIVE).
  - After En+1, either `mv2nxt` is high again or `opendoor` is high.
- `endOpen` seen at edge Em: `opendoor` low after Em, for at least one cycle.
- No combinational path from any input to any output.
- Pend clear on OPEN entry is visible in the same cycle `opendoor` rises.

## Test plan
- Idle at 0, `in_call[2]` pulse. Expect:
  - `mv2nxt` high 2 edges later.
  - Two RUN/ARRIVE cycles, floor going 0 -> 1 -> 2.
  - OPEN at 2 with `pend_in[2]` cleared.
  - `endOpen` -> IDLE, all outputs 0.
- Moving up from 0 with `dn_call[1]` and `in_call[3]` pending:
  - Passes floor 1 (ARRIVE -> RUN) and opens at 3.
  - Reverses (`dir_up` = 0), runs down and opens at 1.
- Idle at 1, `up_call[1]` pulse -> `opendoor` = 1 after 2 edges, floor stays 1, `mv2nxt` never high.
- During OPEN at 2, pulse `in_call[2]` and `in_call[0]`:
  - `pend_in[2]` stays 0.
  - `pend_in[0]` = 1.
  - After `endOpen`, direction goes down and the car reaches floor 0.
- `open_btn` while idle with no calls -> OPEN; `open_btn` while in RUN has no effect.
- Assert `rst` during RUN at floor 2 -> in the same cycle `mv2nxt` = 0, floor = 0, pend = 0, `dir_up` = 1.

Source files
------------

// File: rtl/elevator_scheduler.sv
// elevator_scheduler
//   SCAN car-motion sequencer for the elevator controller (CP domain).
//   Latches car/hall calls, tracks floor and travel direction, and drives
//   the run timer (mv2nxt/endRun) and door timer (opendoor/endOpen).
// Ports:
//   CP, rst                  clock, async active-high reset
//   in_call/up_call/dn_call  button pulses (up_call top bit, dn_call bit 0 ignored)
//   open_btn                 door-open request, honoured only while idle
//   endRun, endOpen          timer-done levels
//   mv2nxt, opendoor         registered timer enables
//   floor, dir_up            current floor / travel direction (1 = up)
//   pend_in/pend_up/pend_dn  latched calls for the lamps
module elevator_scheduler #(
    parameter int NFLOOR = 4,
    parameter int FW     = 2
) (
    input  logic              CP,
    input  logic              rst,
    input  logic [NFLOOR-1:0] in_call,
    input  logic [NFLOOR-1:0] up_call,
    input  logic [NFLOOR-1:0] dn_call,
    input  logic              open_btn,
    input  logic              endRun,
    input  logic              endOpen,
    output logic              mv2nxt,
    output logic              opendoor,
    output logic [FW-1:0]     floor,
    output logic              dir_up,
    output logic [NFLOOR-1:0] pend_in,
    output logic [NFLOOR-1:0] pend_up,
    output logic [NFLOOR-1:0] pend_dn
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_ARRIVE, S_OPEN} state_t;

    // No hall-up button at the top floor, no hall-down button at the bottom.
    localparam logic [NFLOOR-1:0] UP_OK = {1'b0, {(NFLOOR-1){1'b1}}};
    localparam logic [NFLOOR-1:0] DN_OK = {{(NFLOOR-1){1'b1}}, 1'b0};
    localparam logic [FW-1:0]     TOP   = FW'(NFLOOR - 1);

    state_t            r_state, w_nxt;
    logic [FW-1:0]     r_floor, w_floor_nxt;
    logic              r_dir, w_dir_nxt;
    logic              r_mv2nxt, r_opendoor;
    logic [NFLOOR-1:0] r_pin, r_pup, r_pdn;
    logic [NFLOOR-1:0] w_all, w_cur, w_clr;
    logic              w_here, w_above, w_below, w_stop;

    // Call summary relative to the current floor.
    always_comb begin
        w_all   = r_pin | r_pup | r_pdn;
        w_cur   = '0;
        w_above = 1'b0;
        w_below = 1'b0;
        for (int f = 0; f < NFLOOR; f++) begin
            if (FW'(f) == r_floor) w_cur[f] = 1'b1;
            if (FW'(f) >  r_floor) w_above = w_above | w_all[f];
            if (FW'(f) <  r_floor) w_below = w_below | w_all[f];
        end
        w_here = |(w_all & w_cur);
    end

    // ARRIVE stop decision: serve car calls and same-direction hall calls;
    // an opposite-direction hall call is only served when nothing lies
    // further ahead. The end floors always stop so the floor never wraps.
    always_comb begin
        if (r_dir)
            w_stop = (|(w_cur & (r_pin | r_pup | (r_pdn & {NFLOOR{!w_above}}))))
                     || (r_floor == TOP);
        else
            w_stop = (|(w_cur & (r_pin | r_pdn | (r_pup & {NFLOOR{!w_below}}))))
                     || (r_floor == '0);
    end

    always_comb begin
        w_nxt       = r_state;
        w_floor_nxt = r_floor;
        w_dir_nxt   = r_dir;
        case (r_state)
            S_IDLE: begin
                if (w_here || open_btn) begin
                    w_nxt = S_OPEN;
                end else if (r_dir && w_above) begin
                    w_nxt = S_RUN;
                end else if (!r_dir && w_below) begin
                    w_nxt = S_RUN;
                end else if (w_above) begin
                    w_nxt     = S_RUN;
                    w_dir_nxt = 1'b1;
                end else if (w_below) begin
                    w_nxt     = S_RUN;
                    w_dir_nxt = 1'b0;
                end
            end
            S_RUN: begin
                if (endRun) begin
                    w_nxt       = S_ARRIVE;
                    w_floor_nxt = r_dir ? r_floor + FW'(1) : r_floor - FW'(1);
                end
            end
            S_ARRIVE: w_nxt = w_stop ? S_OPEN : S_RUN;
            S_OPEN:   if (endOpen) w_nxt = S_IDLE;
            default:  w_nxt = S_IDLE;
        endcase
    end

    // Current-floor calls are wiped on the edge entering OPEN and on every
    // edge spent in OPEN; the clear overrides a simultaneous set.
    assign w_clr = (r_state == S_OPEN || w_nxt == S_OPEN) ? w_cur : '0;

    always_ff @(posedge CP or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_floor    <= '0;
            r_dir      <= 1'b1;
            r_mv2nxt   <= 1'b0;
            r_opendoor <= 1'b0;
            r_pin      <= '0;
            r_pup      <= '0;
            r_pdn      <= '0;
        end else begin
            r_state    <= w_nxt;
            r_floor    <= w_floor_nxt;
            r_dir      <= w_dir_nxt;
            r_mv2nxt   <= (w_nxt == S_RUN);
            r_opendoor <= (w_nxt == S_OPEN);
            r_pin      <= (r_pin | in_call)           & ~w_clr;
            r_pup      <= (r_pup | (up_call & UP_OK)) & ~w_clr;
            r_pdn      <= (r_pdn | (dn_call & DN_OK)) & ~w_clr;
        end
    end

    assign mv2nxt   = r_mv2nxt;
    assign opendoor = r_opendoor;
    assign floor    = r_floor;
    assign dir_up   = r_dir;
    assign pend_in  = r_pin;
    assign pend_up  = r_pup;
    assign pend_dn  = r_pdn;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Bench for elevator_scheduler: a vector table, directed multi-cycle
// scenarios, then random traffic against a behavioural model.
module tb_elevator_scheduler;

    localparam int NF = 4;

    logic          CP = 1'b0;
    logic          rst;
    logic [NF-1:0] in_call, up_call, dn_call;
    logic          open_btn, endRun, endOpen;
    logic          mv2nxt, opendoor, dir_up;
    logic [1:0]    floor;
    logic [NF-1:0] pend_in, pend_up, pend_dn;

    int n_vec = 0;
    int n_bad = 0;

    elevator_scheduler #(.NFLOOR(NF), .FW(2)) dut (
        .CP(CP), .rst(rst),
        .in_call(in_call), .up_call(up_call), .dn_call(dn_call),
        .open_btn(open_btn), .endRun(endRun), .endOpen(endOpen),
        .mv2nxt(mv2nxt), .opendoor(opendoor), .floor(floor), .dir_up(dir_up),
        .pend_in(pend_in), .pend_up(pend_up), .pend_dn(pend_dn)
    );

    always #5 CP = ~CP;

    typedef struct {
        logic [3:0] ic;
        logic       er, eo;
        logic       mv, od;
        logic [1:0] fl;
        logic       dir;
        logic [3:0] pin;
    } vec_t;

    vec_t tbl[14];

    function automatic vec_t V(logic [3:0] ic, logic er, logic eo, logic mv,
                               logic od, logic [1:0] fl, logic dir, logic [3:0] pin);
        vec_t v;
        v.ic = ic; v.er = er; v.eo = eo; v.mv = mv; v.od = od;
        v.fl = fl; v.dir = dir; v.pin = pin;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic ck(input string nm, input logic mv, od, input logic [1:0] fl, input logic dir);
        chk(nm, 32'({mv2nxt, opendoor, floor, dir_up}), 32'({mv, od, fl, dir}));
    endtask

    task automatic cyc(input logic [3:0] ic, uc, dc, input logic ob, er, eo);
        in_call = ic; up_call = uc; dn_call = dc;
        open_btn = ob; endRun = er; endOpen = eo;
        @(posedge CP);
        #1;
    endtask

    // ---------------- behavioural reference ----------------
    localparam int P_IDLE = 0, P_RUN = 1, P_ARR = 2, P_OPEN = 3;
    int       m_ph, m_fl;
    bit       m_dir;
    bit [3:0] m_pin, m_pup, m_pdn;

    task automatic m_reset();
        m_ph = P_IDLE; m_fl = 0; m_dir = 1'b1;
        m_pin = '0; m_pup = '0; m_pdn = '0;
    endtask

    task automatic m_step(input logic [3:0] ic, uc, dc, input logic ob, er, eo);
        int nph = m_ph;
        int nfl = m_fl;
        bit ndir = m_dir;
        bit here, above, below, stop;
        here  = m_pin[m_fl] | m_pup[m_fl] | m_pdn[m_fl];
        above = 1'b0;
        below = 1'b0;
        for (int f = 0; f < NF; f++) begin
            if (m_pin[f] | m_pup[f] | m_pdn[f]) begin
                if (f > m_fl) above = 1'b1;
                if (f < m_fl) below = 1'b1;
            end
        end
        case (m_ph)
            P_IDLE: begin
                // keep heading the same way if there is work that way, else turn
                if (here || ob) nph = P_OPEN;
                else if (above && (m_dir || !below)) begin nph = P_RUN; ndir = 1'b1; end
                else if (below) begin nph = P_RUN; ndir = 1'b0; end
            end
            P_RUN: if (er) begin nfl = m_fl + (m_dir ? 1 : -1); nph = P_ARR; end
            P_ARR: begin
                if (m_dir) stop = (m_fl == NF-1) || m_pin[m_fl] || m_pup[m_fl] || (m_pdn[m_fl] && !above);
                else       stop = (m_fl == 0)    || m_pin[m_fl] || m_pdn[m_fl] || (m_pup[m_fl] && !below);
                nph = stop ? P_OPEN : P_RUN;
            end
            default: if (eo) nph = P_IDLE;
        endcase
        for (int f = 0; f < NF; f++) begin
            if (f == m_fl && (m_ph == P_OPEN || nph == P_OPEN)) begin
                m_pin[f] = 1'b0; m_pup[f] = 1'b0; m_pdn[f] = 1'b0;
            end else begin
                m_pin[f] = m_pin[f] | ic[f];
                m_pup[f] = m_pup[f] | (uc[f] && f < NF-1);
                m_pdn[f] = m_pdn[f] | (dc[f] && f > 0);
            end
        end
        m_ph = nph; m_fl = nfl; m_dir = ndir;
    endtask

    task automatic rcyc(input int idx);
        logic [3:0] ic, uc, dc;
        logic ob, er, eo;
        logic [16:0] exp;
        ic = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'd0;
        uc = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'd0;
        dc = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'd0;
        ob = ($urandom_range(0, 9) == 0);
        er = ($urandom_range(0, 2) == 0);
        eo = ($urandom_range(0, 2) == 0);
        cyc(ic, uc, dc, ob, er, eo);
        m_step(ic, uc, dc, ob, er, eo);
        exp = {m_ph == P_RUN, m_ph == P_OPEN, 2'(m_fl), m_dir, m_pin, m_pup, m_pdn};
        chk($sformatf("rand%0d", idx),
            32'({mv2nxt, opendoor, floor, dir_up, pend_in, pend_up, pend_dn}), 32'(exp));
    endtask

    initial begin
        rst = 1'b1;
        in_call = '0; up_call = '0; dn_call = '0;
        open_btn = 1'b0; endRun = 1'b0; endOpen = 1'b0;

        // in_call[2] from idle at 0, then car calls 2 and 0 pressed while open at 2
        tbl[0]  = V(4'b0100, 0, 0, 0, 0, 2'd0, 1, 4'b0100);
        tbl[1]  = V(4'b0000, 0, 0, 1, 0, 2'd0, 1, 4'b0100);
        tbl[2]  = V(4'b0000, 1, 0, 0, 0, 2'd1, 1, 4'b0100);
        tbl[3]  = V(4'b0000, 0, 0, 1, 0, 2'd1, 1, 4'b0100);
        tbl[4]  = V(4'b0000, 1, 0, 0, 0, 2'd2, 1, 4'b0100);
        tbl[5]  = V(4'b0000, 0, 0, 0, 1, 2'd2, 1, 4'b0000);
        tbl[6]  = V(4'b0101, 0, 0, 0, 1, 2'd2, 1, 4'b0001);
        tbl[7]  = V(4'b0000, 0, 1, 0, 0, 2'd2, 1, 4'b0001);
        tbl[8]  = V(4'b0000, 0, 0, 1, 0, 2'd2, 0, 4'b0001);
        tbl[9]  = V(4'b0000, 1, 0, 0, 0, 2'd1, 0, 4'b0001);
        tbl[10] = V(4'b0000, 0, 0, 1, 0, 2'd1, 0, 4'b0001);
        tbl[11] = V(4'b0000, 1, 0, 0, 0, 2'd0, 0, 4'b0001);
        tbl[12] = V(4'b0000, 0, 0, 0, 1, 2'd0, 0, 4'b0000);
        tbl[13] = V(4'b0000, 0, 1, 0, 0, 2'd0, 0, 4'b0000);

        repeat (2) @(posedge CP);
        #3 rst = 1'b0;
        chk("reset", 32'({mv2nxt, opendoor, floor, dir_up, pend_in, pend_up, pend_dn}),
            32'({1'b0, 1'b0, 2'd0, 1'b1, 12'd0}));

        for (int i = 0; i < 14; i++) begin
            cyc(tbl[i].ic, 4'd0, 4'd0, 1'b0, tbl[i].er, tbl[i].eo);
            chk($sformatf("tbl%0d", i), 32'({mv2nxt, opendoor, floor, dir_up, pend_in}),
                32'({tbl[i].mv, tbl[i].od, tbl[i].fl, tbl[i].dir, tbl[i].pin}));
        end

        // From 0 with in_call[3] and dn_call[1]: pass 1, open at 3, reverse, open at 1.
        cyc(4'b1000, 4'b0000, 4'b0010, 0, 0, 0);
        chk("scan_latch", 32'({pend_in, pend_dn}), 32'({4'b1000, 4'b0010}));
        cyc(4'd0, 4'd0, 4'd0, 0, 0, 0); ck("scan_run0",  1, 0, 2'd0, 1);
        cyc(4'd0, 4'd0, 4'd0, 0, 1, 0); ck("scan_arr1",  0, 0, 2'd1, 1);
        cyc(4'd0, 4'd0, 4'd0, 0, 1, 0); ck("scan_pass1", 1, 0, 2'd1, 1);
        cyc(4'd0, 4'd0, 4'd0, 0, 1, 0);
        cyc(4'd0, 4'd0, 4'd0, 0, 1, 0); ck("scan_pass2", 1, 0, 2'd2, 1);
        cyc(4'd0, 4'd0, 4'd0, 0, 1, 0); ck("scan_arr3",  0, 0, 2'd3, 1);
        cyc(4'd0, 4'd0, 4'd0, 0, 0, 0); ck("scan_open3", 0, 1, 2'd3, 1);
        chk("scan_clr3", 32'({pend_in, pend_dn}), 32'({4'b0000, 4'b0010}));
        cyc(4'd0, 4'd0, 4'd0, 0, 0, 1); ck("scan_idle3", 0, 0, 2'd3, 1);
        cyc(4'd0, 4'd0, 4'd0, 0, 0, 0); ck("scan_rev",   1, 0, 2'd3, 0);
        cyc(4'd0, 4'd0, 4'd0, 0, 1, 0);
        cyc(4'd0, 4'd0, 4'd0, 0, 1, 0); ck("scan_dpass2", 1, 0, 2'd2, 0);
        cyc(4'd0, 4'd0, 4'd0, 0, 1, 0);
        cyc(4'd0, 4'd0, 4'd0, 0, 0, 0); ck("scan_open1", 0, 1, 2'd1, 0);
        chk("scan_clr1", 32'(pend_dn), 32'(4'b0000));
        cyc(4'd0, 4'd0, 4'd0, 0, 0, 1);

        // Idle at 1, hall-up call at the same floor: door only, no motion.
        cyc(4'd0, 4'b0010, 4'd0, 0, 0, 0); ck("here_e0", 0, 0, 2'd1, 0);
        chk("here_latch", 32'(pend_up), 32'(4'b0010));
        cyc(4'd0, 4'd0, 4'd0, 0, 0, 0);    ck("here_open", 0, 1, 2'd1, 0);
        chk("here_clr", 32'(pend_up), 32'(4'b0000));
        cyc(4'd0, 4'd0, 4'd0, 0, 0, 1);

        // open_btn: honoured in IDLE, ignored in RUN.
        cyc(4'd0, 4'd0, 4'd0, 1, 0, 0); ck("obtn_idle", 0, 1, 2'd1, 0);
        cyc(4'd0, 4'd0, 4'd0, 0, 0, 1); ck("obtn_close", 0, 0, 2'd1, 0);
        cyc(4'b1000, 4'd0, 4'd0, 0, 0, 0);
        cyc(4'd0, 4'd0, 4'd0, 0, 0, 0); ck("obtn_run", 1, 0, 2'd1, 1);
        cyc(4'd0, 4'd0, 4'd0, 1, 0, 0); ck("obtn_inrun", 1, 0, 2'd1, 1);
        cyc(4'd0, 4'd0, 4'd0, 0, 1, 0);
        cyc(4'd0, 4'd0, 4'd0, 0, 0, 0); ck("run_at2", 1, 0, 2'd2, 1);

        // Async reset mid-RUN takes effect without a clock edge.
        in_call = '0; open_btn = 1'b0; endRun = 1'b0; endOpen = 1'b0;
        #2 rst = 1'b1;
        #1 chk("rst_midrun", 32'({mv2nxt, opendoor, floor, dir_up, pend_in, pend_up, pend_dn}),
               32'({1'b0, 1'b0, 2'd0, 1'b1, 12'd0}));
        m_reset();
        #2 rst = 1'b0;

        for (int i = 0; i < 3000; i++) rcyc(i);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
